branch_resolve_ctrl: RTL

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/branch_resolve_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: latches a branch, drives an external comparator,
// decodes taken/mispredict, and holds the result until the consumer accepts it.
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_rs1_data,
  input  logic [31:0]      i_rs2_data,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_imm,
  input  logic             i_pred_taken,
  output logic [31:0]      o_br_rs1_data,
  output logic [31:0]      o_br_rs2_data,
  output logic             o_br_un,
  input  logic             i_br_eq,
  input  logic             i_br_lt,
  input  logic             i_flush,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_illegal,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q;
  logic [31:0] rs1_q, rs2_q, pc_q, imm_q;
  logic        pred_q;
  logic        taken_q, mispred_q, illegal_q;
  logic [31:0] redirect_q;
  logic [CNT_W-1:0] br_cnt, mispred_cnt;
  logic        accept, resp_fire, cmp_taken, cmp_illegal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Flush overrides every transition, including a same-cycle request or handshake.
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_req_valid) next_state = CMP;
        CMP:     next_state = RESP;
        RESP:    if (i_resp_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    o_req_ready   = (state == IDLE) && !i_flush;
    o_resp_valid  = (state == RESP) && !i_flush;
    o_taken       = o_resp_valid & taken_q;
    o_mispredict  = o_resp_valid & mispred_q;
    o_illegal     = o_resp_valid & illegal_q;
    o_redirect_pc = o_resp_valid ? redirect_q : 32'd0;
    o_br_rs1_data = rs1_q;
    o_br_rs2_data = rs2_q;
    o_br_un       = funct3_q[1];
  end

  assign accept    = i_req_valid && o_req_ready;
  assign resp_fire = o_resp_valid && i_resp_ready;
  assign o_br_cnt      = br_cnt;
  assign o_mispred_cnt = mispred_cnt;

  always_comb begin
    cmp_taken   = 1'b0;
    cmp_illegal = 1'b0;
    case (funct3_q)
      3'b000:          cmp_taken = i_br_eq;
      3'b001:          cmp_taken = !i_br_eq;
      3'b100, 3'b110:  cmp_taken = i_br_lt;
      3'b101, 3'b111:  cmp_taken = !i_br_lt;
      default:         cmp_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      funct3_q   <= 3'd0;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      pc_q       <= 32'd0;
      imm_q      <= 32'd0;
      pred_q     <= 1'b0;
      taken_q    <= 1'b0;
      mispred_q  <= 1'b0;
      illegal_q  <= 1'b0;
      redirect_q <= 32'd0;
    end else begin
      if (accept) begin
        funct3_q <= i_funct3;
        rs1_q    <= i_rs1_data;
        rs2_q    <= i_rs2_data;
        pc_q     <= i_pc;
        imm_q    <= i_imm;
        pred_q   <= i_pred_taken;
      end
      // Comparator results are captured on the last edge of CMP.
      if (state == CMP && !i_flush) begin
        taken_q    <= cmp_taken;
        mispred_q  <= !cmp_illegal && (cmp_taken != pred_q);
        illegal_q  <= cmp_illegal;
        redirect_q <= cmp_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (resp_fire && !illegal_q) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (mispred_q && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule
